// File: rtl/hilo_div_unit_pkg.sv
// hilo_div_unit_pkg: shared constants and divider state encoding for the HI/LO unit
package hilo_div_unit_pkg;
    localparam int DIV_STEPS = 32;
    localparam logic [31:0] HILO_RST = 32'h0;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/hilo_div_unit_div_core.sv
// hilo_div_unit_div_core: iterative radix-2 restoring divider with sign fix-up
//   clk, rst_n           clock, async active-low reset
//   start, is_signed     divide request (sampled in IDLE), DIV vs DIVU
//   a, b                 dividend, divisor
//   cancel               abort an in-flight divide
//   quotient, remainder  sign-corrected results, valid while done
//   done                 one-cycle completion pulse
//   busy                 stall request to the pipeline
module hilo_div_unit_div_core
    import hilo_div_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cancel,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done,
    output logic         busy
);
    localparam int CNT_W = $clog2(DIV_STEPS);

    div_state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0] q, b_mag, a_mag, b_in;
    logic [W:0] rem;
    logic q_sign, r_sign;
    logic [W+1:0] trial, diff;
    logic ge, last;

    assign a_mag = (is_signed && a[W-1]) ? -a : a;
    assign b_in  = (is_signed && b[W-1]) ? -b : b;
    assign last  = cnt == CNT_W'(DIV_STEPS - 1);

    // Dividend bits shift out of q into the remainder while quotient bits shift in.
    // The remainder stays below the divisor, so the trial never exceeds 33 bits and
    // diff's top bit is a clean borrow flag.
    assign trial = {rem, q[W-1]};
    assign diff  = trial - {2'b00, b_mag};
    assign ge    = ~diff[W+1];

    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = (start && !cancel) ? CALC : IDLE;
        else if (cancel)
            state_n = IDLE;
        else if (state == CALC)
            state_n = last ? DONE : CALC;
        else
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            q      <= '0;
            b_mag  <= '0;
            rem    <= '0;
            q_sign <= 1'b0;
            r_sign <= 1'b0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (start && !cancel) begin
                q      <= a_mag;
                b_mag  <= b_in;
                rem    <= '0;
                // A zero divisor leaves the all-ones quotient un-negated so LO is
                // always 32'hFFFFFFFF; the remainder still regains the dividend.
                q_sign <= is_signed && (a[W-1] ^ b[W-1]) && (b != '0);
                r_sign <= is_signed && a[W-1];
            end
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            q   <= {q[W-2:0], ge};
            rem <= ge ? diff[W:0] : trial[W:0];
        end
    end

    assign quotient  = q_sign ? -q : q;
    assign remainder = r_sign ? -rem[W-1:0] : rem[W-1:0];
    assign done      = (state == DONE) && !cancel;
    assign busy      = (state == IDLE && start && !cancel) || state == CALC;
endmodule

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: architectural HI/LO registers with write-through bypass and divider
//   clk, resetn            clock, async active-low reset
//   hi_we/lo_we, *_wdata   MULT/MTHI/MTLO results from execute
//   div_start, div_signed  divide request and DIV/DIVU select
//   div_a, div_b           dividend, divisor
//   div_cancel             exception flush of an in-flight divide
//   div_stall, div_done    pipeline hold, completion pulse
//   hi_o, lo_o             bypassed HI/LO values for MFHI/MFLO
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [DIV_W-1:0] hi_wdata,
    input  logic [DIV_W-1:0] lo_wdata,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [DIV_W-1:0] div_a,
    input  logic [DIV_W-1:0] div_b,
    input  logic             div_cancel,
    output logic             div_stall,
    output logic             div_done,
    output logic [DIV_W-1:0] hi_o,
    output logic [DIV_W-1:0] lo_o
);
    logic [DIV_W-1:0] hi_q, lo_q, quotient, remainder;

    hilo_div_unit_div_core #(.W(DIV_W)) u_core (
        .clk       (clk),
        .rst_n     (resetn),
        .start     (div_start),
        .is_signed (div_signed),
        .a         (div_a),
        .b         (div_b),
        .cancel    (div_cancel),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (div_done),
        .busy      (div_stall)
    );

    // The finishing divide owns HI/LO in its DONE cycle; execute writes lose.
    assign hi_o = div_done ? remainder : hi_we ? hi_wdata : hi_q;
    assign lo_o = div_done ? quotient  : lo_we ? lo_wdata : lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= HILO_RST;
            lo_q <= HILO_RST;
        end else begin
            hi_q <= hi_o;
            lo_q <= lo_o;
        end
    end
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: scoreboard bench for HI/LO writes, bypass, divides, cancel and reset
module tb_hilo_div_unit;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        hi_we = 1'b0, lo_we = 1'b0, div_start = 1'b0, div_signed = 1'b0, div_cancel = 1'b0;
    logic [31:0] hi_wdata = '0, lo_wdata = '0, div_a = '0, div_b = '0;
    logic        div_stall, div_done;
    logic [31:0] hi_o, lo_o;

    hilo_div_unit #(.DIV_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_cancel (div_cancel),
        .div_stall  (div_stall),
        .div_done   (div_done),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && div_done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got div_done=1 want no completion (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_cycle", cyc, mon_e.at);
                chk("div_hi", hi_o, mon_e.hi);
                chk("div_lo", lo_o, mon_e.lo);
            end
        end
    end

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        @(posedge clk);
        #1;
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = h; lo_wdata = l;
        #1;
        chk("bypass_hi", hi_o, h);
        chk("bypass_lo", lo_o, l);
        @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0;
        #1;
        chk("held_hi", hi_o, h);
        chk("held_lo", lo_o, l);
    endtask

    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic poke);
        int nlo;
        @(posedge clk);
        #1;
        div_start = 1'b1; div_signed = sg; div_a = a; div_b = b;
        sbq.push_back('{cyc + 33, eh, el});
        @(negedge clk);
        chk("stall_c0", {31'b0, div_stall}, 32'd1);
        @(posedge clk);
        #1;
        div_start = 1'b0;
        nlo = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (!div_stall) nlo++;
            if (poke && i == 5) div_start = 1'b1;
            if (poke && i == 7) div_start = 1'b0;
        end
        chk("stall_calc_low_cycles", nlo, 0);
        @(negedge clk);
        chk("stall_done", {31'b0, div_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("persist_hi", hi_o, eh);
        chk("persist_lo", lo_o, el);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_stall", {31'b0, div_stall}, 32'd0);
        chk("rst_done", {31'b0, div_done}, 32'd0);
        resetn = 1'b1;

        write_hilo(32'h1234_5678, 32'h9ABC_DEF0);

        do_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        do_div(1'b0, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b1, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);

        write_hilo(32'd1, 32'd2);
        @(posedge clk);
        #1;
        div_start = 1'b1; div_signed = 1'b0; div_a = 32'd1000; div_b = 32'd3;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        div_cancel = 1'b1;
        @(posedge clk);
        #1;
        div_cancel = 1'b0;
        #1;
        chk("cancel_stall", {31'b0, div_stall}, 32'd0);
        chk("cancel_hi", hi_o, 32'd1);
        chk("cancel_lo", lo_o, 32'd2);
        repeat (30) @(posedge clk);
        #1;
        chk("cancel_later_hi", hi_o, 32'd1);
        chk("cancel_later_lo", lo_o, 32'd2);

        @(posedge clk);
        #1;
        div_start = 1'b1; div_a = 32'd77; div_b = 32'd5;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_hi", hi_o, 32'h0);
        chk("arst_lo", lo_o, 32'h0);
        chk("arst_stall", {31'b0, div_stall}, 32'd0);
        chk("arst_done", {31'b0, div_done}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("after_arst_hi", hi_o, 32'h0);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
